// File: rtl/fetch_unit.sv
// PC / instruction-register fetch stage with stall, flushing jumps and end-of-program handling.
// Define FETCH_PC_WRAP_EN to make the PC wrap to 0 after the last program word instead of stopping.
module fetch_unit #(
    parameter int ADDR_W   = 4,
    parameter int INST_W   = 8,
    parameter int PROG_LEN = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [INST_W-1:0] inst_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [INST_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic              jump_err,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);
    localparam logic [ADDR_W:0]   PROG_LEN_X = (ADDR_W + 1)'(PROG_LEN);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              load;
    logic              bad_jump;

    assign mem_addr = pc;
    assign bad_jump = {1'b0, jump_addr} >= PROG_LEN_X;

    // Successor address; at the last word it either wraps or parks.
    always_comb begin
        pc_next = pc + ADDR_W'(1);
        if (pc == LAST_ADDR) begin
`ifdef FETCH_PC_WRAP_EN
            pc_next = '0;
`else
            pc_next = pc;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        if (jump_en) begin
            state_next = FLUSH;
        end else if (!stall) begin
            case (state)
                FILL, FLUSH: begin
                    load       = 1'b1;
                    state_next = RUN;
                end
                RUN: begin
`ifdef FETCH_PC_WRAP_EN
                    load = 1'b1;
`else
                    // The last word already sits in ir, so the program is exhausted.
                    if (ir_pc == LAST_ADDR) begin
                        state_next = DONE;
                    end else begin
                        load = 1'b1;
                    end
`endif
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= '0;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            jump_err <= 1'b0;
        end else begin
            jump_err <= 1'b0;
            if (jump_en) begin
                pc       <= bad_jump ? '0 : jump_addr;
                ir_valid <= 1'b0;
                jump_err <= bad_jump;
            end else if (load) begin
                ir       <= inst_in;
                ir_pc    <= pc;
                ir_valid <= 1'b1;
                pc       <= pc_next;
            end else if (state_next == DONE) begin
                ir_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PC_WRAP_EN
    assign done = 1'b0;
`else
    assign done = (state == DONE);
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Program-counter and instruction-register stage in front of the 16-entry, 8-bit combinational instruction memory.
- Drives the memory address, latches the returned instruction into `ir`, and presents it with a valid flag to the downstream decoder.
- Supports stall, decoder-requested jumps with a one-cycle flush bubble, and end-of-program handling.

## Interface
- `ADDR_W`, default 4: PC / memory address width.
- `INST_W`, default 8: instruction width.
- `PROG_LEN`, default 9: number of valid program words; the last valid address is `PROG_LEN-1`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `stall`  in  1  hold the PC, IR and state this cycle.
- `jump_en`  in  1  decoder requests a PC redirect.
- `jump_addr`  in  `ADDR_W`  redirect target.
- `inst_in`  in  `INST_W`  instruction word returned by the memory for `mem_addr`, valid in the same cycle.
- `mem_addr`  out  `ADDR_W`  instruction memory address; combinationally equal to `pc`.
- `ir`  out  `INST_W`  latched instruction.
- `ir_pc`  out  `ADDR_W`  address the `ir` word was fetched from.
- `ir_valid`  out  1  `ir` holds a live instruction.
- `jump_err`  out  1  one-cycle pulse when `jump_addr >= PROG_LEN`.
- `done`  out  1  program exhausted; only used when wrap is compiled out.

## Operation
- **Internal state:** register `pc`, plus a state machine FILL / RUN / FLUSH / DONE.
- **Reset** (`rst_n`=0 at an edge):
  - `pc`=0, `ir`=0, `ir_pc`=0, `ir_valid`=0, `jump_err`=0, `done`=0.
  - State goes to FILL.
- **FILL / FLUSH, edge with !stall and !jump_en:**
  - `ir`<=`inst_in`, `ir_pc`<=`pc`, `ir_valid`<=1.
  - `pc`<=next(`pc`).
  - State goes to RUN.
- **RUN, edge with !stall and !jump_en:** same IR load and PC advance; state stays RUN.
- **next(p):**
  - p+1 when p < `PROG_LEN-1`.
  - At `PROG_LEN-1`, behaviour is set by Configuration.
- **Jump** (`jump_en`=1 in any state; has priority over `stall`):
  - `pc`<=`jump_addr`, `ir_valid`<=0, `done`<=0, state goes to FLUSH.
  - The word currently on `inst_in` is discarded.
  - If `jump_addr >= PROG_LEN`: `pc`<=0 instead, and `jump_err`=1 for that one cycle.
- **Stall** (without jump): every register holds, including `ir_valid`. `mem_addr` stays stable.
- **DONE:** `pc` holds, `ir_valid`=0, `done`=1.
  - Exits only on reset, or on `jump_en` (goes to FLUSH).
- **Width rules:**
  - All PC arithmetic is `ADDR_W` bits with no carry-out.
  - The `jump_addr` comparison is unsigned.

## Timing
- Fetch latency:
  - After reset release, the first `ir_valid` is at edge 1 (FILL load).
  - Throughput is one instruction per unstalled cycle thereafter.
- Jump penalty is exactly one bubble:
  - Edge N samples `jump_en`; `ir_valid`=0 after edge N.
  - Edge N+1 loads `ir`=mem[`jump_addr`] with `ir_valid`=1.
- Simultaneous `jump_en` and `stall`: the jump wins.
- Reset mid-operation:
  - Applies at the next edge regardless of `stall` or `jump_en`.
  - In-flight `ir` is cleared.
- `jump_err` is registered: high for exactly the cycle after the sampling edge.

## Configuration
- Macro: `FETCH_PC_WRAP_EN`.
- **Defined:**
  - next(`PROG_LEN-1`) = 0; execution loops forever.
  - `done` is tied to 0 and the DONE state is unreachable.
- **Undefined:**
  - Loading address `PROG_LEN-1` into `ir` leaves `pc`=`PROG_LEN-1`.
  - The next unstalled edge (no jump) sets `ir_valid`=0, `done`=1 and enters DONE.

## Test plan
- **Reset, then free run** with memory 08,19,20,10,70,00,14,04,B2:
  - `ir` reads 08,19,20,… on edges 1,2,3,… with `ir_pc` 0,1,2,…
  - `ir_valid`=1 from edge 1.
- **Stall** held high for 3 cycles while `ir`=20 (`ir_pc`=2):
  - `ir`, `ir_pc`, `mem_addr`=3 and `ir_valid` are unchanged for 3 cycles.
  - 10 loads on the first edge after release.
- **Jump** with `jump_addr`=6 while `ir`=19:
  - One cycle with `ir_valid`=0.
  - Then `ir`=14 with `ir_pc`=6, then 04.
- **Bad jump and jump-over-stall:**
  - `jump_addr`=12 with `stall`=1: `jump_err` pulses once; the next valid `ir`=08 with `ir_pc`=0.
- **End of program:**
  - Without `FETCH_PC_WRAP_EN`: after B2 (`ir_pc`=8), `done`=1 and `ir_valid`=0 and both hold for 10 cycles. A jump to 0 then clears `done` and refetches 08.
  - With the macro: B2 is followed by 08 (`ir_pc`=0), and `done` stays 0.
- **Reset mid-run** asserted while `ir`=70:
  - Next edge: `ir`=0, `ir_valid`=0, `mem_addr`=0.
  - After release, the refill gives 08 on the first edge.
